// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB bus arbiter: registered one-hot grant with binary index,
// ownership held until an HREADY-completed release or a bounded-hold preemption.
module ahb_rr_arbiter #(
  parameter int NUM_MANAGERS = 4,
  parameter int MAXHOLD      = 16,
  localparam int IW = $clog2(NUM_MANAGERS),
  localparam int HW = $clog2(MAXHOLD)
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [NUM_MANAGERS-1:0] Request,
  input  logic                    HREADY,
  output logic [NUM_MANAGERS-1:0] Grant,
  output logic [IW-1:0]           GrantIndex,
  output logic                    GrantValid
);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                  r_state;
  logic [NUM_MANAGERS-1:0] r_grant;
  logic [IW-1:0]           r_idx;
  logic                    r_valid;
  logic [IW-1:0]           r_ptr;
  logic [HW-1:0]           r_hold;

  logic [NUM_MANAGERS-1:0] w_cand;
  logic                    w_found;
  logic [IW-1:0]           w_win;
  logic                    w_own_req;
  logic                    w_hold_max;
  logic [NUM_MANAGERS-1:0] w_win_onehot;
  logic [IW-1:0]           w_ptr_next;

  // The current owner (if any) is masked out so a re-pick never returns it.
  assign w_cand     = Request & ~r_grant;
  assign w_own_req  = |(Request & r_grant);
  assign w_hold_max = (r_hold == HW'(MAXHOLD - 1));

  always_comb begin
    int j;
    w_found = 1'b0;
    w_win   = '0;
    j       = 0;
    for (int k = 0; k < NUM_MANAGERS; k++) begin
      j = (int'(r_ptr) + k) % NUM_MANAGERS;
      if (!w_found && w_cand[j]) begin
        w_found = 1'b1;
        w_win   = IW'(j);
      end
    end
  end

  assign w_win_onehot = {{(NUM_MANAGERS-1){1'b0}}, 1'b1} << w_win;
  assign w_ptr_next   = (w_win == IW'(NUM_MANAGERS - 1)) ? '0 : w_win + IW'(1);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= OWNED;
            r_grant <= w_win_onehot;
            r_idx   <= w_win;
            r_valid <= 1'b1;
            r_ptr   <= w_ptr_next;
            r_hold  <= '0;
          end
        end
        OWNED: begin
          if (HREADY) begin
            if (w_found && (!w_own_req || w_hold_max)) begin
              // Release or preemption with a waiting requester: back-to-back handover.
              r_grant <= w_win_onehot;
              r_idx   <= w_win;
              r_ptr   <= w_ptr_next;
              r_hold  <= '0;
            end else if (!w_own_req) begin
              r_state <= IDLE;
              r_grant <= '0;
              r_valid <= 1'b0;
              r_hold  <= '0;
            end else if (!w_hold_max) begin
              r_hold  <= r_hold + HW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Grant      = r_grant;
  assign GrantIndex = r_idx;
  assign GrantValid = r_valid;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Bench for ahb_rr_arbiter: vector table, hand sequences for reset/preemption,
// and randomized traffic against an integer-level ownership model.
module tb_ahb_rr_arbiter;

  localparam int N  = 4;
  localparam int MH = 16;

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic [N-1:0] Request;
  logic         HREADY;
  logic [N-1:0] Grant;
  logic [1:0]   GrantIndex;
  logic         GrantValid;

  int total = 0;
  int bad   = 0;

  // Model state: owner index or -1 when idle.
  int m_owner, m_ptr, m_hold, m_idx;

  typedef struct {
    logic [N-1:0] req;
    logic         rdy;
    logic [N-1:0] g;
    logic [1:0]   idx;
    logic         v;
  } vec_t;

  vec_t tbl[16];

  ahb_rr_arbiter #(.NUM_MANAGERS(N), .MAXHOLD(MH)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .Request(Request), .HREADY(HREADY),
    .Grant(Grant), .GrantIndex(GrantIndex), .GrantValid(GrantValid)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] cand, input int ptr);
    for (int k = 0; k < N; k++)
      if (cand[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic m_grant(input int w);
    m_owner = w;
    m_idx   = w;
    m_ptr   = (w + 1) % N;
    m_hold  = 0;
  endtask

  task automatic m_reset();
    m_owner = -1; m_ptr = 0; m_hold = 0; m_idx = 0;
  endtask

  task automatic model_step(input logic [N-1:0] req, input logic rdy);
    int w;
    if (m_owner < 0) begin
      w = rr_pick(req, m_ptr);
      if (w >= 0) m_grant(w);
    end else if (rdy) begin
      logic [N-1:0] others;
      others = req;
      others[m_owner] = 1'b0;
      w = rr_pick(others, m_ptr);
      if (!req[m_owner]) begin
        if (w >= 0) m_grant(w);
        else begin m_owner = -1; m_hold = 0; end
      end else if (m_hold == MH - 1 && w >= 0) begin
        m_grant(w);
      end else if (m_hold < MH - 1) begin
        m_hold++;
      end
    end
  endtask

  function automatic logic [N-1:0] m_grant_vec();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic invariants();
    check("onehot0", {31'd0, $onehot0(Grant)}, 32'd1);
    check("valid_or", {31'd0, GrantValid}, {31'd0, |Grant});
    if (GrantValid) check("idx_match", {31'd0, Grant[GrantIndex]}, 32'd1);
  endtask

  // Drive at negedge, let the DUT and model take the same edge, sample 1 ns later.
  task automatic apply(input logic [N-1:0] req, input logic rdy);
    @(negedge HCLK);
    Request = req;
    HREADY  = rdy;
    @(posedge HCLK);
    model_step(req, rdy);
    #1;
    invariants();
  endtask

  task automatic check_model(input string name);
    check({name, "_grant"}, {28'd0, Grant}, {28'd0, m_grant_vec()});
    check({name, "_idx"}, {30'd0, GrantIndex}, m_idx);
    check({name, "_valid"}, {31'd0, GrantValid}, {31'd0, m_owner >= 0});
  endtask

  initial begin
    logic [N-1:0] rq;

    tbl[0]  = '{4'b1011, 1'b0, 4'b0001, 2'd0, 1'b1};
    tbl[1]  = '{4'b1010, 1'b1, 4'b0010, 2'd1, 1'b1};
    tbl[2]  = '{4'b1001, 1'b1, 4'b1000, 2'd3, 1'b1};
    tbl[3]  = '{4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1};
    tbl[4]  = '{4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1};
    tbl[5]  = '{4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1};
    tbl[6]  = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1};
    tbl[7]  = '{4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1};
    tbl[8]  = '{4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1};
    tbl[9]  = '{4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1};
    tbl[10] = '{4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1};
    tbl[11] = '{4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1};
    tbl[12] = '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0};
    tbl[13] = '{4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1};
    tbl[14] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
    tbl[15] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};

    HRESETn = 1'b0;
    Request = '0;
    HREADY  = 1'b0;
    m_reset();
    repeat (2) @(posedge HCLK);
    #1;
    check("rst_grant", {28'd0, Grant}, 32'd0);
    check("rst_idx", {30'd0, GrantIndex}, 32'd0);
    check("rst_valid", {31'd0, GrantValid}, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Back-to-back order, wait states with dropped request, wrap-around pick.
    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].req, tbl[i].rdy);
      check($sformatf("vec%0d_grant", i), {28'd0, Grant}, {28'd0, tbl[i].g});
      check($sformatf("vec%0d_idx", i), {30'd0, GrantIndex}, {30'd0, tbl[i].idx});
      check($sformatf("vec%0d_valid", i), {31'd0, GrantValid}, {31'd0, tbl[i].v});
    end

    // Preemption after exactly MAXHOLD HREADY-high edges.
    apply(4'b0001, 1'b0);
    check("pre_start", {28'd0, Grant}, 32'h1);
    for (int i = 1; i <= MH; i++) begin
      apply(4'b1001, 1'b1);
      if (i < MH) check($sformatf("pre_hold%0d", i), {28'd0, Grant}, 32'h1);
      else        check("pre_move", {28'd0, Grant}, 32'h8);
    end
    apply(4'b0000, 1'b1);
    check("pre_idle", {31'd0, GrantValid}, 32'd0);

    // Lone owner keeps the bus; a late competitor preempts at the saturated count.
    apply(4'b0001, 1'b0);
    for (int i = 0; i < 40; i++) begin
      apply(4'b0001, 1'b1);
      check($sformatf("lone%0d", i), {28'd0, Grant}, 32'h1);
    end
    apply(4'b1001, 1'b1);
    check("sat_preempt", {28'd0, Grant}, 32'h8);
    check("sat_preempt_idx", {30'd0, GrantIndex}, 32'd3);
    apply(4'b0000, 1'b1);

    // Asynchronous reset in the middle of an ownership.
    apply(4'b0010, 1'b0);
    check("mid_own", {28'd0, Grant}, 32'h2);
    #2;
    HRESETn = 1'b0;
    m_reset();
    #1;
    check("async_grant", {28'd0, Grant}, 32'd0);
    check("async_valid", {31'd0, GrantValid}, 32'd0);
    check("async_idx", {30'd0, GrantIndex}, 32'd0);
    @(posedge HCLK);
    #1;
    check("async_hold", {28'd0, Grant}, 32'd0);
    HRESETn = 1'b1;
    apply(4'b0010, 1'b0);
    check("post_rst_grant", {28'd0, Grant}, 32'h2);
    check("post_rst_idx", {30'd0, GrantIndex}, 32'd1);
    apply(4'b0000, 1'b1);
    check_model("post_rst_idle");

    // Randomized traffic with sticky requests so long holds and preemption occur.
    rq = '0;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
      apply(rq, $urandom_range(0, 3) != 0);
      check_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_rr_arbiter.md
# ahb_rr_arbiter

Round-robin bus arbiter for the AHB multi-manager interconnect. Accepts per-manager request lines and issues a registered one-hot grant plus its binary index, producing the one-hot vector that the interconnect's one-hot-to-binary select logic consumes. Ownership is held until the owner's transfer completes on an `HREADY` beat, with a bounded hold time for fairness.

## Interface
- `NUM_MANAGERS`, 4: number of requesting managers; must be ≥ 2.
- `MAXHOLD`, 16: maximum `HREADY`-high cycles one owner keeps the bus while another manager is waiting; must be ≥ 2.

Ports:
- `HCLK` in 1: the block's only clock; all state changes on its rising edge.
- `HRESETn` in 1: reset; asynchronous, active-low.
- `Request` in `NUM_MANAGERS`: bit i high means manager i wants the bus or is still using it.
- `HREADY` in 1: subordinate ready; a high value marks a completed beat.
- `Grant` out `NUM_MANAGERS`: registered grant; one-hot or all zero.
- `GrantIndex` out `$clog2(NUM_MANAGERS)`: binary index of the current or most recent owner.
- `GrantValid` out 1: high when `Grant` is non-zero.

## Operation
- Reset, asynchronous on `HRESETn` low and effective immediately, including mid-ownership:
  - `Grant`=0, `GrantIndex`=0, `GrantValid`=0.
  - Round-robin pointer `Ptr`=0, hold counter `HoldCnt`=0, state IDLE.
- Round-robin pick:
  - Search `Request` starting at index `Ptr`, ascending, wrapping from `NUM_MANAGERS`-1 to 0.
  - The first set bit wins.
  - On every grant, `Ptr` becomes (winner+1) mod `NUM_MANAGERS`.
- State IDLE, with `Grant`=0:
  - If any `Request` bit is set, register the winner's one-hot grant and go to OWNED with `HoldCnt`=0.
  - `HREADY` is ignored in IDLE.
- State OWNED, with owner o:
  - `HREADY`=0: hold all state; no release, no count.
  - `HREADY`=1 and `Request[o]`=0 (release): pick among the remaining requesters.
    - If one exists, grant it on the same edge (back-to-back, no idle cycle); `HoldCnt`=0.
    - Otherwise go to IDLE with `Grant`=0.
  - `HREADY`=1, `Request[o]`=1, `HoldCnt`=`MAXHOLD`-1, and some other request pending (preemption): grant the round-robin winner, which excludes o; `HoldCnt`=0.
  - `HREADY`=1, `Request[o]`=1, otherwise:
    - `HoldCnt` increments, saturating at `MAXHOLD`-1.
    - With no other requester, o keeps the bus indefinitely.
- `GrantIndex` always equals the binary index of the set `Grant` bit. In IDLE it holds the last owner's index, so the address/data mux stays stable.
- `Grant` never has more than one bit set. The owner's `Request` bit is never considered in the same-edge re-pick.

## Timing
- All outputs are registered; nothing is combinational from inputs to outputs.
- Grant latency from IDLE: `Request` sampled high at edge n gives `Grant` valid after edge n.
- Handover: release or preemption condition sampled at edge k gives the new `Grant` after edge k. The bus is never idle between owners when a requester is pending.
- A request that rises in the same cycle as a release is eligible for that handover.
- Simultaneous requests from IDLE: lowest index at or above `Ptr` (with wrap) wins; the others wait.
- Worst-case wait for a requester: (`NUM_MANAGERS`-1)·`MAXHOLD` `HREADY`-high cycles plus one grant cycle.

## Test plan
- Reset mid-ownership: `Request`=0010, granted; assert `HRESETn`=0 mid-cycle → `Grant`=0000, `GrantValid`=0 immediately. After release, `Request`=0010 → `Grant`=0010 one edge later.
- Simultaneous requests: from reset, `Request`=1011 held, each owner drops its request after 1 `HREADY` beat → grant order 0001, 0010, 1000, 0001, all back-to-back.
- Wait states: owner 2 with `HREADY`=0 for 5 cycles and `Request[2]` dropped → `Grant` stays 0100 until the first `HREADY`=1 edge, then goes to 0000.
- Preemption: owner 0 holds `Request[0]`=1 with `HREADY`=1; `Request[3]`=1 → `Grant` moves to 1000 exactly after the 16th `HREADY`-high edge. Owner 0 alone holding for 40 cycles → `Grant` stays 0001.
- Wrap-around: `Ptr`=3 (last grant index 2), `Request`=0101 → `Grant`=0001, `GrantIndex`=0. Then in IDLE with `Request`=0 → `GrantIndex` stays 0 and `GrantValid`=0.
- Invariant checks on every cycle: `$onehot0(Grant)`, `GrantValid`==|`Grant`, and `GrantIndex` matches `Grant` whenever valid.
